// File: rtl/OoO_pkg.sv
// Shared core types and constants: icache geometry, AXI read-channel structs, icache FSM states.
package OoO_pkg;

  localparam int unsigned IcacheLineSize = 5;
  localparam int unsigned IcacheLineNum  = 1;
  localparam int unsigned IcacheTagW     = 32 - IcacheLineSize - IcacheLineNum;
  localparam int unsigned IcacheLines    = 1 << IcacheLineNum;
  localparam int unsigned IcacheLineBits = 8 << IcacheLineSize;
  localparam int unsigned IcacheBeats    = 8;
  localparam int unsigned IcacheBeatW    = 3;

  localparam logic [1:0] AxiBurstIncr = 2'b01;
  localparam logic [2:0] AxiSize32    = 3'b010;

  typedef struct packed {
    logic                      valid;
    logic [IcacheTagW-1:0]     tag;
    logic [IcacheLineBits-1:0] data;
  } icache_t;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    AR,
    R
  } icache_state_e;

endpackage

// File: rtl/ooo_icache_array.sv
// Direct-mapped icache storage: beat-granular data writes, tag/valid write,
// synchronous invalidate-all and a combinational line read.
module ooo_icache_array
  import OoO_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [IcacheLineNum-1:0] rd_idx_i,
  output icache_t                  rd_line_o,
  input  logic                     beat_we_i,
  input  logic [IcacheLineNum-1:0] wr_idx_i,
  input  logic [IcacheBeatW-1:0]   beat_sel_i,
  input  logic [31:0]              beat_data_i,
  input  logic                     tv_we_i,
  input  logic [IcacheTagW-1:0]    tag_i,
  input  logic                     inval_i
);

  logic [IcacheLines-1:0]    valid_q, valid_d;
  logic [IcacheTagW-1:0]     tag_q  [IcacheLines];
  logic [IcacheTagW-1:0]     tag_d  [IcacheLines];
  logic [IcacheLineBits-1:0] data_q [IcacheLines];
  logic [IcacheLineBits-1:0] data_d [IcacheLines];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (beat_we_i) data_d[wr_idx_i][{beat_sel_i, 5'b0} +: 32] = beat_data_i;
    if (tv_we_i) begin
      valid_d[wr_idx_i] = 1'b1;
      tag_d[wr_idx_i]   = tag_i;
    end
    // Invalidate overrides a same-cycle line completion.
    if (inval_i) valid_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  always_comb begin
    rd_line_o       = '0;
    rd_line_o.valid = valid_q[rd_idx_i];
    rd_line_o.tag   = tag_q[rd_idx_i];
    rd_line_o.data  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/ooo_icache.sv
// Blocking direct-mapped instruction cache; misses refill a full line with one
// AXI INCR burst, fence.i invalidates all lines and kills any in-flight request.
module ooo_icache
  import OoO_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_instr_o,
  input  logic        fence_i_i,
  output axi_r_m2s_t  axi_r_o,
  input  axi_r_s2m_t  axi_r_i
);

  icache_state_e            state_q, state_d;
  logic [31:2]              addr_q, addr_d;
  logic [IcacheBeatW-1:0]   cnt_q, cnt_d;
  logic                     kill_q, kill_d;
  icache_t                  line;
  logic [IcacheLineNum-1:0] idx;
  logic                     hit, beat, last_beat, fill_done;
  logic                     unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign idx       = addr_q[IcacheLineSize +: IcacheLineNum];
  assign hit       = line.valid && (line.tag == addr_q[31 -: IcacheTagW]);
  assign beat      = (state_q == R) && axi_r_i.rvalid;
  assign last_beat = beat && axi_r_i.rlast;
  assign fill_done = last_beat && !kill_q && !fence_i_i;

  ooo_icache_array u_array (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rd_idx_i   (idx),
    .rd_line_o  (line),
    .beat_we_i  (beat),
    .wr_idx_i   (idx),
    .beat_sel_i (cnt_q),
    .beat_data_i(axi_r_i.rdata),
    .tv_we_i    (fill_done),
    .tag_i      (addr_q[31 -: IcacheTagW]),
    .inval_i    (fence_i_i)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !fence_i_i) begin
          addr_d  = req_addr_i[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (fence_i_i)        state_d = IDLE;
        else if (!hit)        state_d = AR;
        else if (rsp_ready_i) state_d = IDLE;
      end
      AR: begin
        if (fence_i_i)        kill_d  = 1'b1;
        if (axi_r_i.arready)  state_d = R;
      end
      R: begin
        // A killed burst must still drain to rlast; only its completion is dropped.
        if (fence_i_i) kill_d = 1'b1;
        if (beat)      cnt_d  = cnt_q + 1'b1;
        if (last_beat) begin
          cnt_d   = '0;
          state_d = (kill_q || fence_i_i) ? IDLE : LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) kill_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    axi_r_o = '0;
    if (state_q == AR) begin
      axi_r_o.arvalid = 1'b1;
      axi_r_o.araddr  = {addr_q[31:IcacheLineSize], {IcacheLineSize{1'b0}}};
      axi_r_o.arlen   = 8'(IcacheBeats - 1);
      axi_r_o.arsize  = AxiSize32;
      axi_r_o.arburst = AxiBurstIncr;
    end
    axi_r_o.rready = (state_q == R);
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == LOOKUP) && hit;
  assign rsp_instr_o = rsp_valid_o ? line.data[{addr_q[IcacheLineSize-1:2], 5'b0} +: 32] : '0;

endmodule

// File: tb/tb_ooo_icache.sv
// Bench for ooo_icache: directed vector table, hand-written fence/reset sequences,
// then random fetches against a tag/valid reference model and a synthetic memory.
module tb_ooo_icache;
  import OoO_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic        fence = 1'b0;
  axi_r_m2s_t  axo;
  axi_r_s2m_t  axi = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ooo_icache dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr),
    .fence_i_i  (fence),
    .axi_r_o    (axo),
    .axi_r_i    (axi)
  );

  // rlast must coincide with the eighth accepted beat of every burst.
  int unsigned beat_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_n <= 0;
    else if (axi.rvalid && axo.rready) begin
      assert (axi.rlast == (beat_n == 7))
        else $display("FAIL rlast_beat actual_beat=%0d rlast=%0b", beat_n, axi.rlast);
      beat_n <= axi.rlast ? 0 : beat_n + 1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    int          fence_at;
    int          stall;
    bit          exp_miss;
    bit          exp_resp;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vt [13];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a[31:5] == 27'h400_0000) return 32'h1000 + {29'd0, a[4:2]};
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_req_ready"}, req_ready, 1);
    chk({p, "_rsp_valid"}, rsp_valid, 0);
    chk({p, "_rsp_instr"}, rsp_instr, 0);
    chk({p, "_araddr"}, axo.araddr, 0);
    chk({p, "_ar_ctl"}, {18'd0, axo.arvalid, axo.rready, axo.arlen, axo.arsize, axo.arburst}, 0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int fence_at, input int stall,
                          input int ar_dly, input bit gaps,
                          output bit miss, output bit resp, output logic [31:0] instr);
    int n;
    logic [31:0] hold;
    logic [31:0] line_a;
    miss  = 0;
    resp  = 0;
    instr = '0;
    line_a = {a[31:5], 5'b0};
    n = 0;
    rsp_ready = 1'b1;
    while (!req_ready && n < 50) begin
      cyc();
      n++;
    end
    rsp_ready = 1'b0;
    chk("idle_before_req", req_ready, 1);

    req_valid = 1'b1;
    req_addr  = a;
    cyc();
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("busy_lookup", req_ready, 0);

    if (rsp_valid) begin
      chk("hit_no_ar", axo.arvalid, 0);
    end else begin
      miss = 1;
      cyc();
      chk("arvalid_lat", axo.arvalid, 1);
      chk("araddr", axo.araddr, line_a);
      chk("arlen", axo.arlen, 7);
      chk("arsize", axo.arsize, 2);
      chk("arburst", axo.arburst, 1);
      chk("busy_ar", req_ready, 0);
      repeat (ar_dly) begin
        cyc();
        chk("arvalid_hold", axo.arvalid, 1);
      end
      axi.arready = 1'b1;
      cyc();
      axi.arready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (gaps && $urandom_range(1, 0) == 1) cyc();
        axi.rvalid = 1'b1;
        axi.rdata  = mem_rd(line_a + 32'(4 * k));
        axi.rlast  = (k == 7);
        fence      = (k == fence_at);
        chk("rready_beat", axo.rready, 1);
        cyc();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        fence      = 1'b0;
      end
      if (fence_at >= 0) begin
        chk("killed_no_rsp", rsp_valid, 0);
        chk("killed_idle", req_ready, 1);
      end else begin
        chk("refill_rsp_lat", rsp_valid, 1);
      end
    end

    if (rsp_valid) begin
      resp  = 1;
      instr = rsp_instr;
      hold  = rsp_instr;
      repeat (stall) begin
        cyc();
        chk("stall_valid", rsp_valid, 1);
        chk("stall_instr", rsp_instr, hold);
        chk("stall_busy", req_ready, 0);
      end
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk("post_rsp_idle", req_ready, 1);
    end
  endtask

  initial begin
    bit          miss, resp, exp_hit, exp_resp;
    logic [31:0] instr, a;
    logic [1:0]  rv;
    logic [25:0] rt [2];
    int          fat;

    vt[0]  = '{32'h8000_0004, -1, 0, 1'b1, 1'b1, 32'h0000_1001};
    vt[1]  = '{32'h8000_001C, -1, 0, 1'b0, 1'b1, 32'h0000_1007};
    vt[2]  = '{32'h8000_0040, -1, 0, 1'b1, 1'b1, 32'hDA5A_0040};
    vt[3]  = '{32'h8000_0020, -1, 0, 1'b1, 1'b1, 32'hDA5A_0020};
    vt[4]  = '{32'h8000_0044, -1, 0, 1'b0, 1'b1, 32'hDA5A_0044};
    vt[5]  = '{32'h8000_0028, -1, 5, 1'b0, 1'b1, 32'hDA5A_0028};
    vt[6]  = '{32'h8000_0004,  3, 0, 1'b1, 1'b0, 32'h0000_0000};
    vt[7]  = '{32'h8000_0004, -1, 0, 1'b1, 1'b1, 32'h0000_1001};
    vt[8]  = '{32'h8000_0020, -1, 0, 1'b1, 1'b1, 32'hDA5A_0020};
    vt[9]  = '{32'h8000_0064,  7, 0, 1'b1, 1'b0, 32'h0000_0000};
    vt[10] = '{32'h8000_0064, -1, 0, 1'b1, 1'b1, 32'hDA5A_0064};
    vt[11] = '{32'h8000_0006, -1, 0, 1'b1, 1'b1, 32'h0000_1001};
    vt[12] = '{32'h8000_0003, -1, 2, 1'b0, 1'b1, 32'h0000_1000};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc();
    chk_reset_outputs("post_reset");

    for (int i = 0; i < 13; i++) begin
      do_fetch(vt[i].addr, vt[i].fence_at, vt[i].stall, i % 3, 1'b0, miss, resp, instr);
      chk($sformatf("v%0d_miss", i), miss, vt[i].exp_miss);
      chk($sformatf("v%0d_resp", i), resp, vt[i].exp_resp);
      if (vt[i].exp_resp) chk($sformatf("v%0d_instr", i), instr, vt[i].exp_instr);
    end

    // fence in IDLE: request refused, and the invalidate forces a later miss
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    fence     = 1'b1;
    cyc();
    req_valid = 1'b0;
    fence     = 1'b0;
    chk("fence_idle_ready", req_ready, 1);
    chk("fence_idle_norsp", rsp_valid, 0);
    cyc();
    chk("fence_idle_noar", axo.arvalid, 0);
    chk("fence_idle_still", rsp_valid, 0);
    do_fetch(32'h8000_0000, -1, 0, 0, 1'b0, miss, resp, instr);
    chk("fence_idle_remiss", miss, 1);
    chk("fence_idle_instr", instr, 32'h0000_1000);

    // fence in LOOKUP on a hit: dropped, back to IDLE, line now invalid
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    cyc();
    req_valid = 1'b0;
    chk("fence_lkp_hit", rsp_valid, 1);
    fence = 1'b1;
    cyc();
    fence = 1'b0;
    chk("fence_lkp_idle", req_ready, 1);
    chk("fence_lkp_norsp", rsp_valid, 0);
    do_fetch(32'h8000_0008, -1, 0, 1, 1'b0, miss, resp, instr);
    chk("fence_lkp_remiss", miss, 1);
    chk("fence_lkp_instr", instr, 32'h0000_1002);

    // asynchronous reset in the middle of a refill
    req_valid = 1'b1;
    req_addr  = 32'h8000_0044;
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("rst_mid_ar", axo.arvalid, 1);
    axi.arready = 1'b1;
    cyc();
    axi.arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = mem_rd(32'h8000_0040 + 32'(4 * k));
      cyc();
    end
    axi.rvalid = 1'b0;
    chk("rst_mid_rready", axo.rready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    cyc();
    rst_n = 1'b1;
    cyc();
    do_fetch(32'h8000_0044, -1, 0, 0, 1'b0, miss, resp, instr);
    chk("rst_mid_remiss", miss, 1);
    chk("rst_mid_instr", instr, 32'hDA5A_0044);

    rv     = 2'b01;
    rt[0]  = 26'h200_0001;
    rt[1]  = '0;
    for (int i = 0; i < 60; i++) begin
      a   = 32'h8000_0000 + 32'($urandom_range(5, 0) * 32) + 32'($urandom_range(7, 0) * 4)
            + 32'($urandom_range(3, 0));
      fat = ($urandom_range(9, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      exp_hit = rv[a[5]] && (rt[a[5]] == a[31:6]);
      do_fetch(a, fat, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b1,
               miss, resp, instr);
      chk("rnd_miss", miss, !exp_hit);
      exp_resp = exp_hit || (fat < 0);
      chk("rnd_resp", resp, exp_resp);
      if (exp_resp) chk("rnd_instr", instr, mem_rd(a));
      if (!exp_hit) begin
        if (fat >= 0) rv = '0;
        else begin
          rv[a[5]] = 1'b1;
          rt[a[5]] = a[31:6];
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
